// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad (Pmod KYPD layout) one column at a time,
//   debounces whole-keypad scans and reports a single hex key code.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   row[3:0]    keypad rows, active-low, asynchronous to clk
//   col[3:0]    keypad columns, active-low, exactly one low at a time
//   key[3:0]    hex code of the last accepted key
//   key_valid   one-cycle strobe when a press is accepted
//   key_pressed high while the accepted key is held
module keypad_scanner #(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  logic [3:0]    rowMeta_q, rowSync_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    accHits_q;
  logic [3:0]    accCode_q;

  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] dbCnt_q, dbCnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;

  logic          sampleEn, scanDone;
  logic [2:0]    colHits;
  logic [3:0]    colCode;
  logic [2:0]    hitSum;
  logic [1:0]    passHits;
  logic [3:0]    passCode;

  // Row r / column c to the hex code printed on the keypad.
  function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign col         = ~(4'b0001 << idx_q);
  assign key         = key_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

  assign sampleEn = (cnt_q == LAST_TICK);
  assign scanDone = sampleEn && (idx_q == 2'd3);

  // Hits in the currently driven column merged with the hits already seen
  // this pass. The hit count saturates at 2, which is all MULTI needs.
  always_comb begin
    colHits = 3'd0;
    colCode = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!rowSync_q[r]) begin
        if (colHits == 3'd0) colCode = keyMap(2'(r), idx_q);
        colHits = colHits + 3'd1;
      end
    end
    hitSum   = {1'b0, accHits_q} + colHits;
    passHits = (hitSum >= 3'd2) ? 2'd2 : hitSum[1:0];
    passCode = (accHits_q == 2'd1) ? accCode_q : colCode;
  end

  // Row synchronizer, column dwell/index and the per-pass hit accumulator.
  // The accumulator clears on the column-3 sample so each pass starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      accHits_q <= 2'd0;
      accCode_q <= 4'h0;
    end else begin
      rowMeta_q <= row;
      rowSync_q <= rowMeta_q;
      if (sampleEn) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          accHits_q <= 2'd0;
          accCode_q <= 4'h0;
        end else begin
          accHits_q <= passHits;
          accCode_q <= passCode;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Debounce FSM, stepped once per completed scan. Accepting a key and
  // releasing it both happen on the edge that samples column 3.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    dbCnt_d   = dbCnt_q;
    key_d     = key_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    if (scanDone) begin
      case (state_q)
        IDLE: begin
          if (passHits == 2'd1) begin
            cand_d = passCode;
            if (DEBOUNCE_SCANS == 1) begin
              key_d     = passCode;
              pressed_d = 1'b1;
              valid_d   = 1'b1;
              dbCnt_d   = '0;
              state_d   = HELD;
            end else begin
              dbCnt_d = DW'(1);
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (passHits == 2'd1) begin
            if (passCode == cand_q) begin
              if (dbCnt_q + DW'(1) == DB_TARGET) begin
                key_d     = cand_q;
                pressed_d = 1'b1;
                valid_d   = 1'b1;
                dbCnt_d   = '0;
                state_d   = HELD;
              end else begin
                dbCnt_d = dbCnt_q + DW'(1);
              end
            end else begin
              cand_d  = passCode;
              dbCnt_d = DW'(1);
            end
          end else begin
            dbCnt_d = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (passHits == 2'd0) begin
            if (DEBOUNCE_SCANS == 1) begin
              pressed_d = 1'b0;
              dbCnt_d   = '0;
              state_d   = IDLE;
            end else begin
              dbCnt_d = DW'(1);
              state_d = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (passHits == 2'd0) begin
            if (dbCnt_q + DW'(1) == DB_TARGET) begin
              pressed_d = 1'b0;
              dbCnt_d   = '0;
              state_d   = IDLE;
            end else begin
              dbCnt_d = dbCnt_q + DW'(1);
            end
          end else begin
            dbCnt_d = '0;
            state_d = HELD;
          end
        end
        default: begin
          dbCnt_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= 4'h0;
      dbCnt_q   <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      dbCnt_q   <= dbCnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3, so one
//   full scan is 16 cycles. A keypad model turns a 16-bit key matrix
//   (bit r*4+c) into row levels from the driven columns. Expected presses
//   are queued with their code and arrival cycle; a monitor pops them on
//   every key_valid strobe.
module tb_keypad_scanner;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys;

  int   vectors;
  int   miscompares;
  int   cycNum;
  logic prevValid;
  exp_t expQ[$];

  logic [3:0] keyTable [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K8 = 16'h0200;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KD = 16'h8000;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key         (key),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  // A row reads low when any closed switch on it sits on a driven column.
  function automatic logic [3:0] rowModel(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign row = rowModel(keys, col);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp relative to the last reset, read on negedges.
  always @(posedge clk) begin
    if (reset) cycNum <= 0;
    else       cycNum <= cycNum + 1;
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycNum);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] newKeys, input int nScans);
    keys = newKeys;
    repeat (16 * nScans) @(negedge clk);
  endtask

  task automatic expectPress(input logic [3:0] code, input int nScans);
    exp_t e;
    e.code = code;
    e.cyc  = cycNum + 16 * nScans;
    expQ.push_back(e);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued press in
  // code and arrival cycle, and strobes must never be back to back.
  initial prevValid = 1'b0;
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      vectors++;
      if (prevValid) begin
        miscompares++;
        $display("[TB] FAIL valid_consecutive: key_valid high two cycles in a row at cycle %0d", cycNum);
      end
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_valid: key_valid with key %h at cycle %0d, expected none", key, cycNum);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("valid_key", key, e.code);
        vectors++;
        if (cycNum != e.cyc) begin
          miscompares++;
          $display("[TB] FAIL valid_cycle: strobe at cycle %0d, expected cycle %0d", cycNum, e.cyc);
        end
      end
    end
    prevValid = (key_valid === 1'b1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    keys        = 16'h0000;
    reset       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    checkOutput("reset_col", col, 4'b1110);
    checkOutput("reset_key", key, 4'h0);
    checkOutput("reset_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("reset_pressed", {3'b0, key_pressed}, 4'h0);
    reset = 1'b0;

    // Column sweep with nothing pressed, including the wrap back to column 0.
    for (int k = 0; k < 16; k++) begin
      checkOutput("col_sweep", col, ~(4'b0001 << (k / 4)));
      @(negedge clk);
    end
    checkOutput("col_wrap", col, 4'b1110);

    // Clean press of '5', then a debounced release.
    expectPress(4'h5, 3);
    applyStimulus(K5, 3);
    checkOutput("clean_pressed", {3'b0, key_pressed}, 4'h1);
    checkOutput("clean_key", key, 4'h5);
    applyStimulus(16'h0000, 2);
    checkOutput("clean_rel_partial", {3'b0, key_pressed}, 4'h1);
    applyStimulus(16'h0000, 1);
    checkOutput("clean_released", {3'b0, key_pressed}, 4'h0);
    checkOutput("clean_key_kept", key, 4'h5);

    // Bouncing contact: on/off alternating for four scans, then stable.
    applyStimulus(K5, 1);
    applyStimulus(16'h0000, 1);
    applyStimulus(K5, 1);
    applyStimulus(16'h0000, 1);
    checkOutput("bounce_not_pressed", {3'b0, key_pressed}, 4'h0);
    expectPress(4'h5, 3);
    applyStimulus(K5, 3);
    checkOutput("bounce_key", key, 4'h5);
    applyStimulus(16'h0000, 3);

    // Two keys together are ignored; dropping one leaves a clean single press.
    applyStimulus(K1 | K9, 3);
    checkOutput("multi_not_pressed", {3'b0, key_pressed}, 4'h0);
    expectPress(4'h1, 3);
    applyStimulus(K1, 3);
    checkOutput("multi_then_single_key", key, 4'h1);
    checkOutput("multi_then_single_pressed", {3'b0, key_pressed}, 4'h1);
    applyStimulus(16'h0000, 3);

    // 'D' with a short release gap that must not count as a new press.
    expectPress(4'hD, 3);
    applyStimulus(KD, 3);
    applyStimulus(16'h0000, 2);
    checkOutput("gap_still_pressed", {3'b0, key_pressed}, 4'h1);
    applyStimulus(KD, 2);
    checkOutput("gap_repress_pressed", {3'b0, key_pressed}, 4'h1);
    applyStimulus(16'h0000, 3);
    checkOutput("gap_released", {3'b0, key_pressed}, 4'h0);
    checkOutput("gap_key_kept", key, 4'hD);

    // Every key position maps to its printed code.
    for (int i = 0; i < 16; i++) begin
      expectPress(keyTable[i], 3);
      applyStimulus(16'h0001 << i, 3);
      checkOutput("keymap", key, keyTable[i]);
      applyStimulus(16'h0000, 3);
    end

    // Reset in PRESS_DB at count 2 while column 2 is driven.
    applyStimulus(K8, 2);
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_col", col, 4'b1011);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_col", col, 4'b1110);
    checkOutput("midreset_key", key, 4'h0);
    checkOutput("midreset_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("midreset_pressed", {3'b0, key_pressed}, 4'h0);
    reset = 1'b0;
    expectPress(4'h8, 3);
    applyStimulus(K8, 2);
    checkOutput("post_reset_not_yet", {3'b0, key_pressed}, 4'h0);
    applyStimulus(K8, 1);
    checkOutput("post_reset_key", key, 4'h8);
    checkOutput("post_reset_pressed", {3'b0, key_pressed}, 4'h1);
    applyStimulus(16'h0000, 3);

    // Every queued press must have been seen.
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending_presses: %0d strobes never arrived, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and sampling the four row lines.
- Debounces the result and outputs a single 4-bit hex key code with a one-cycle valid strobe and a held-level flag.
- It is the input-side counterpart of the multiplexed seven-segment display path. Its key code feeds display digit registers or control logic.

Parameters:
- SCAN_TICKS, 1000, clock cycles each column stays driven; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active-low (pulled up), asynchronous to clk
- col  output  4  keypad columns, active-low, exactly one bit low at all times
- key  output  4  hex code of last accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_pressed  output  1  high while an accepted key is held

Behaviour:
- Reset values:
  - col=4'b1110 (column 0).
  - Column index=0, dwell counter=0.
  - key=4'h0, key_valid=0, key_pressed=0.
  - Debounce count=0, FSM state=IDLE.
  - Synchronizer flops are set to 4'b1111.
- Row synchronization: `row` passes through a 2-flop synchronizer before any use.
- Column drive:
  - col = ~(4'b0001 << idx).
  - The dwell counter runs 0..SCAN_TICKS-1.
  - When the counter is at SCAN_TICKS-1, the synchronized rows are sampled. On the same edge, idx increments and wraps 3->0, and the counter returns to 0.
- Scan result: evaluated when the column-3 sample is taken, covering all four columns of that pass. Three outcomes:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection is low.
  - MULTI: two or more intersections are low.
- Key map (row r, col c). Columns 0..3 from left to right:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states, evaluated once per completed scan:
  - IDLE:
    - SINGLE(x): candidate=x, count=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - SINGLE(x) with x==candidate: count++. When count reaches DEBOUNCE_SCANS, accept.
    - SINGLE(y) with y!=candidate: candidate=y, count=1.
    - NONE or MULTI: go to IDLE, count=0.
  - Accept: key<=candidate, key_pressed<=1, key_valid=1 for exactly one cycle, go to HELD.
    - key_valid rises in the cycle after the edge that samples column 3 of the qualifying scan.
  - HELD:
    - NONE: count=1, go to REL_DB. If DEBOUNCE_SCANS=1, release immediately instead.
    - SINGLE (any key) or MULTI: stay in HELD. No new key_valid while held, and key is unchanged.
  - REL_DB:
    - NONE: count++. When count reaches DEBOUNCE_SCANS, release: key_pressed<=0, go to IDLE. key holds its value.
    - Any key: go back to HELD.
- Boundary conditions:
  - key_valid never asserts on two consecutive cycles.
  - key_valid fires at most once per press/release cycle.
  - Reset asserted mid-scan or mid-debounce restores all reset values on the next edge. Scanning restarts at column 0 with a full dwell.
  - The counter width must hold SCAN_TICKS-1. The debounce counter must hold DEBOUNCE_SCANS.

Test Plan:
- Clean press, SCAN_TICKS=4, DEBOUNCE_SCANS=3 (one scan = 16 cycles):
  - Stimulus: hold row[1] low only while col==4'b1101.
  - Required: key=4'h5, key_pressed=1, and a single 1-cycle key_valid at the end of the 3rd full scan.
- Bounce:
  - Stimulus: the '5' contact toggles every other scan for 4 scans, then stays stable.
  - Required: no key_valid until 3 consecutive stable scans. Then exactly one pulse, key=4'h5.
- Two keys:
  - Stimulus: '1' (r0,c0) and '9' (r2,c2) pressed together from IDLE.
  - Required: stays in IDLE, no key_valid, key_pressed=0.
  - Then release '9' while holding '1': key=4'h1 after 3 scans.
- Release and hold:
  - Stimulus: press 'D' (r3,c3), accept it, release for 2 scans, press again, then release for 3 scans.
  - Required: key_pressed stays 1 through the 2-scan gap with no second key_valid. It drops after the 3-scan release. key remains 4'hD.
- Column sweep:
  - Stimulus: no keys pressed; observe col.
  - Required: col steps 1110, 1101, 1011, 0111, 1110, each pattern for 4 cycles, never more than one bit low.
  - Check all 16 key positions map to the table codes.
- Reset mid-operation:
  - Stimulus: assert reset during PRESS_DB at count=2 with col=4'b1011.
  - Required: next edge gives col=1110, key=0, key_valid=0, key_pressed=0.
  - After reset is released, a fresh press needs 3 full scans to be accepted.
